// File: rtl/timer_pkg.sv
// Shared timing constants, channel state encoding and the prescaler width helper
// for the FCU timer blocks.
package timer_pkg;

  localparam int unsigned DEF_CLK_MHZ = 50;
  localparam int unsigned DEF_CW      = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Sub-counter width for a prescaler that counts 0..clk_mhz-1.
  function automatic int unsigned div_w(input int unsigned clk_mhz);
    return (clk_mhz <= 2) ? 1 : $clog2(clk_mhz);
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One microsecond timer channel: FSM, us prescaler, delay counter, shadow
// delay/mode registers and the registered expiry pulse.
module timer_chan
  import timer_pkg::*;
#(
  parameter int unsigned DIV = DEF_CLK_MHZ,
  parameter int unsigned CW  = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_periodic,
  input  logic [CW-1:0] i_nus,
  output logic          o_busy,
  output logic          o_timeup
);

  localparam int unsigned SW = div_w(DIV);

  state_e        r_state, w_state_nxt;
  logic [SW-1:0] r_sub,   w_sub_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [CW-1:0] r_nus,   w_nus_nxt;
  logic          r_per,   w_per_nxt;
  logic          r_timeup, w_timeup_nxt;
  logic          w_wrap;
  logic          w_last;

  assign w_wrap = (r_sub == SW'(DIV - 1));
  assign w_last = w_wrap && (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sub    <= '0;
      r_cnt    <= '0;
      r_nus    <= '0;
      r_per    <= 1'b0;
      r_timeup <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sub    <= w_sub_nxt;
      r_cnt    <= w_cnt_nxt;
      r_nus    <= w_nus_nxt;
      r_per    <= w_per_nxt;
      r_timeup <= w_timeup_nxt;
    end
  end

  // Start beats stop and expiry; stop beats expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_sub_nxt    = r_sub;
    w_cnt_nxt    = r_cnt;
    w_nus_nxt    = r_nus;
    w_per_nxt    = r_per;
    w_timeup_nxt = 1'b0;
    if (i_start) begin
      w_nus_nxt = i_nus;
      w_per_nxt = i_periodic;
      w_cnt_nxt = i_nus;
      w_sub_nxt = '0;
      if (i_nus == '0) begin
        w_state_nxt  = ST_IDLE;
        w_timeup_nxt = 1'b1;
      end else begin
        w_state_nxt  = ST_RUN;
      end
    end else if (r_state == ST_RUN) begin
      if (i_stop) begin
        w_state_nxt = ST_IDLE;
        w_sub_nxt   = '0;
      end else begin
        w_sub_nxt = w_wrap ? '0 : r_sub + SW'(1);
        if (w_wrap) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
        if (w_last) begin
          w_timeup_nxt = 1'b1;
          if (r_per) begin
            w_cnt_nxt = r_nus;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
    end
  end

  assign o_busy   = (r_state == ST_RUN);
  assign o_timeup = r_timeup;

endmodule

// File: rtl/timer_array_us.sv
// NCH-channel microsecond timer array with independent per-channel prescalers.
// Optional IRQ aggregation (irq_clr/irq_pend/irq) is enabled by TIMER_IRQ_EN.
module timer_array_us
  import timer_pkg::*;
#(
  parameter int unsigned CLK_MHZ = DEF_CLK_MHZ,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = DEF_CW
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH-1:0]    periodic,
  input  logic [NCH*CW-1:0] nus,
`ifdef TIMER_IRQ_EN
  input  logic [NCH-1:0]    irq_clr,
  output logic [NCH-1:0]    irq_pend,
  output logic              irq,
`endif
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    timeup
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    timer_chan #(
      .DIV (CLK_MHZ),
      .CW  (CW)
    ) u_chan (
      .clk        (CLK),
      .rst_n      (RSTn),
      .i_start    (start[g]),
      .i_stop     (stop[g]),
      .i_periodic (periodic[g]),
      .i_nus      (nus[g*CW +: CW]),
      .o_busy     (busy[g]),
      .o_timeup   (timeup[g])
    );
  end

`ifdef TIMER_IRQ_EN
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] w_pend_nxt;
  logic           r_irq;

  // A new expiry wins over a concurrent clear.
  always_comb begin
    w_pend_nxt = (r_pend & ~irq_clr) | timeup;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pend <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_irq  <= |w_pend_nxt;
    end
  end

  assign irq_pend = r_pend;
  assign irq      = r_irq;
`endif

endmodule

// File: tb/tb_timer_array_us.sv
// Self-checking bench for timer_array_us (CLK_MHZ=50, NCH=4, CW=16); covers the
// IRQ aggregation too when built with TIMER_IRQ_EN.
module tb_timer_array_us;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int DIV = 50;

  logic              CLK;
  logic              RSTn;
  logic [NCH-1:0]    start;
  logic [NCH-1:0]    stop;
  logic [NCH-1:0]    periodic;
  logic [NCH*CW-1:0] nus;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    timeup;
`ifdef TIMER_IRQ_EN
  logic [NCH-1:0]    irq_clr;
  logic [NCH-1:0]    irq_pend;
  logic              irq;
`endif

  timer_array_us #(.CLK_MHZ(DIV), .NCH(NCH), .CW(CW)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .nus      (nus),
`ifdef TIMER_IRQ_EN
    .irq_clr  (irq_clr),
    .irq_pend (irq_pend),
    .irq      (irq),
`endif
    .busy     (busy),
    .timeup   (timeup)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Deadline-based model: each running channel knows the absolute edge it fires on.
  int       cyc = 0;
  logic [NCH-1:0] m_run, m_tu, m_per;
  int       m_fire[NCH];
  int       m_period[NCH];
  logic [NCH-1:0] m_pend;
  logic     m_irq;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_run  = '0;
      m_tu   = '0;
      m_per  = '0;
      m_pend = '0;
      m_irq  = 1'b0;
    end else begin
      cyc++;
`ifdef TIMER_IRQ_EN
      m_pend = (m_pend & ~irq_clr) | m_tu;
      m_irq  = |m_pend;
`endif
      for (int i = 0; i < NCH; i++) begin
        int n;
        n = int'(nus[i*CW +: CW]);
        m_tu[i] = 1'b0;
        if (start[i]) begin
          if (n == 0) begin
            m_run[i] = 1'b0;
            m_tu[i]  = 1'b1;
          end else begin
            m_run[i]    = 1'b1;
            m_per[i]    = periodic[i];
            m_period[i] = n * DIV;
            m_fire[i]   = cyc + n * DIV;
          end
        end else if (m_run[i] && stop[i]) begin
          m_run[i] = 1'b0;
        end else if (m_run[i] && cyc == m_fire[i]) begin
          m_tu[i] = 1'b1;
          if (m_per[i]) m_fire[i] = m_fire[i] + m_period[i];
          else          m_run[i]  = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RSTn) begin
      chk("busy", 32'(busy), 32'(m_run));
      chk("timeup", 32'(timeup), 32'(m_tu));
`ifdef TIMER_IRQ_EN
      chk("irq_pend", 32'(irq_pend), 32'(m_pend));
      chk("irq", 32'(irq), 32'(m_irq));
`endif
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic wait_tu(input int ch, input int budget, output int at);
    at = -1;
    for (int j = 0; j < budget; j++) begin
      @(negedge CLK);
      if (timeup[ch]) begin
        at = cyc;
        return;
      end
    end
  endtask

  int k, at;

  initial begin
    RSTn = 1'b0; start = '0; stop = '0; periodic = '0; nus = '0;
`ifdef TIMER_IRQ_EN
    irq_clr = '0;
`endif
    #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_timeup", 32'(timeup), 32'h0);
    repeat (3) step();
    RSTn = 1'b1;
    repeat (2) step();

    // Case 1: one-shot ch0, 3 us
    nus[0*CW +: CW] = 16'd3; periodic[0] = 1'b0; start[0] = 1'b1;
    step(); k = cyc; start = '0;
    chk("c1_busy_start", 32'(busy[0]), 32'h1);
    wait_tu(0, 200, at);
    chk("c1_latency", 32'(at - k), 32'd150);
    chk("c1_busy_fall", 32'(busy[0]), 32'h0);
    wait_tu(0, 200, at);
    chk("c1_single", 32'(at), 32'hffffffff);

    // Case 2: periodic ch1, 2 us; later nus edits must be ignored
    nus[1*CW +: CW] = 16'd2; periodic[1] = 1'b1; start[1] = 1'b1;
    step(); k = cyc; start = '0; periodic = '0;
    nus[1*CW +: CW] = 16'd7;
    wait_tu(1, 200, at); chk("c2_p1", 32'(at - k), 32'd100);
    wait_tu(1, 200, at); chk("c2_p2", 32'(at - k), 32'd200);
    wait_tu(1, 200, at); chk("c2_p3", 32'(at - k), 32'd300);
    wait_until(k + 349);
    stop[1] = 1'b1; step(); stop = '0;
    chk("c2_stop_busy", 32'(busy[1]), 32'h0);
    wait_tu(1, 200, at);
    chk("c2_no_more", 32'(at), 32'hffffffff);

    // Case 3: restart with a shorter delay, then zero delay
    nus[2*CW +: CW] = 16'd10; start[2] = 1'b1;
    step(); k = cyc; start = '0;
    wait_until(k + 199);
    nus[2*CW +: CW] = 16'd1; start[2] = 1'b1;
    step(); start = '0;
    wait_tu(2, 100, at);
    chk("c3_restart", 32'(at - k), 32'd250);
    wait_tu(2, 600, at);
    chk("c3_no_old", 32'(at), 32'hffffffff);
    nus[2*CW +: CW] = 16'd0; periodic[2] = 1'b1; start[2] = 1'b1;
    step(); start = '0; periodic = '0;
    chk("c3_zero_tu", 32'(timeup[2]), 32'h1);
    chk("c3_zero_busy", 32'(busy[2]), 32'h0);
    repeat (3) step();

    // Case 4: collisions
    nus[3*CW +: CW] = 16'd5; start[3] = 1'b1; stop[3] = 1'b1;
    step(); k = cyc; start = '0; stop = '0;
    chk("c4_start_wins", 32'(busy[3]), 32'h1);
    wait_until(k + 249);
    stop[3] = 1'b1; step(); stop = '0;
    chk("c4_stop_exp_tu", 32'(timeup[3]), 32'h0);
    chk("c4_stop_exp_busy", 32'(busy[3]), 32'h0);
    repeat (3) step();
    for (int i = 0; i < NCH; i++) nus[i*CW +: CW] = 16'd1;
    start = '1;
    step(); k = cyc; start = '0;
    wait_tu(0, 100, at);
    chk("c4_all_lat", 32'(at - k), 32'd50);
    chk("c4_all_tu", 32'(timeup), 32'hf);
    repeat (3) step();

    // Case 5: async reset mid-run on ch3
    nus[3*CW +: CW] = 16'd4; start[3] = 1'b1;
    step(); start = '0;
    repeat (60) step();
    chk("c5_running", 32'(busy[3]), 32'h1);
    #2 RSTn = 1'b0;
    #1;
    chk("c5_rst_busy", 32'(busy), 32'h0);
    chk("c5_rst_tu", 32'(timeup), 32'h0);
`ifdef TIMER_IRQ_EN
    chk("c5_rst_pend", 32'(irq_pend), 32'h0);
`endif
    repeat (2) step();
    RSTn = 1'b1;
    wait_tu(3, 300, at);
    chk("c5_silent", 32'(at), 32'hffffffff);

`ifdef TIMER_IRQ_EN
    // Case 6: pending flag, and set beating a concurrent clear
    nus[0*CW +: CW] = 16'd1; periodic[0] = 1'b1; start[0] = 1'b1;
    step(); start = '0; periodic = '0;
    wait_tu(0, 100, at);
    step();
    chk("c6_pend", 32'(irq_pend[0]), 32'h1);
    chk("c6_irq", 32'(irq), 32'h1);
    wait_until(at + 50);
    chk("c6_tu2", 32'(timeup[0]), 32'h1);
    irq_clr[0] = 1'b1; step(); irq_clr = '0;
    chk("c6_set_wins", 32'(irq_pend[0]), 32'h1);
    repeat (3) step();
    irq_clr[0] = 1'b1; step(); irq_clr = '0;
    chk("c6_clr_pend", 32'(irq_pend[0]), 32'h0);
    chk("c6_clr_irq", 32'(irq), 32'h0);
    stop[0] = 1'b1; step(); stop = '0;
    repeat (3) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
